ge_add: RTL and testbench

//  Ed25519 point addition, ref10 style: P (extended X:Y:Z:T) + Q (cached Y+X, Y-X, Z, 2dT) -> R (completed/p1p1 X:Y:Z:T).

---
 rtl/ge_add.sv | 196 +++++++++++++++++++
 tb/tb_ge_add.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ge_add.sv
// Ed25519 point addition (ref10 ge_add): extended P + cached Q -> completed R.
// One GF(2^255-19) multiplier is shared across four products. It builds one output column per cycle.
module ge_add (
  input  logic [319:0] p_x,
  input  logic [319:0] p_y,
  input  logic [319:0] p_z,
  input  logic [319:0] p_t,
  input  logic [319:0] q_yplusx,
  input  logic [319:0] q_yminusx,
  input  logic [319:0] q_z,
  input  logic [319:0] q_t2d,
  output logic [319:0] r_x,
  output logic [319:0] r_y,
  output logic [319:0] r_z,
  output logic [319:0] r_t,
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         done
);

  // Handshake: valid is a start pulse that is honoured only in IDLE, where all inputs are captured.
  // done is high for exactly one cycle, in the DONE state, when r_* first carry the new result.
  // r_* keep their value until the next accepted valid completes.
  typedef enum logic [2:0] {
    IDLE, LOAD, MUL1, MUL2, MUL3, MUL4, FINAL, DONE
  } state_t;

  typedef logic [9:0][63:0] wide_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic [319:0]  r_px, r_py, r_pz, r_pt, r_qp, r_qm, r_qz, r_qt;
  logic [319:0]  r_a, r_b, r_z1, r_y1, r_t1, r_x1;
  wide_t         r_h;
  logic [319:0]  w_f, w_g, w_prod, w_t0;
  logic [31:0]   w_gl [10];
  logic signed [63:0] w_col;
  logic          w_mul_last;

  function automatic logic [319:0] fe_add(input logic [319:0] a, input logic [319:0] b);
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    return r;
  endfunction

  function automatic logic [319:0] fe_sub(input logic [319:0] a, input logic [319:0] b);
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = a[32*i +: 32] - b[32*i +: 32];
    return r;
  endfunction

  function automatic logic [3:0] carry_idx(input int s);
    logic [3:0] r;
    case (s)
      0: r = 4'd0;  1: r = 4'd4;  2: r = 4'd1;  3: r = 4'd5;
      4: r = 4'd2;  5: r = 4'd6;  6: r = 4'd3;  7: r = 4'd7;
      8: r = 4'd4;  9: r = 4'd8;  10: r = 4'd9; default: r = 4'd0;
    endcase
    return r;
  endfunction

  // ref10 carry chain; the carry out of limb 9 wraps to limb 0 scaled by 19.
  function automatic logic [319:0] fe_carry(input wide_t h_in);
    logic signed [63:0] h [10];
    logic signed [63:0] c;
    logic [3:0]         idx, nxt;
    logic [319:0]       r;
    for (int n = 0; n < 10; n++) h[n] = signed'(h_in[n]);
    c = '0;
    for (int s = 0; s < 12; s++) begin
      idx = carry_idx(s);
      nxt = (idx == 4'd9) ? 4'd0 : idx + 4'd1;
      if (!idx[0]) begin
        c = (h[idx] + 64'sd33554432) >>> 26;
        h[idx] = h[idx] - (c <<< 26);
      end else begin
        c = (h[idx] + 64'sd16777216) >>> 25;
        h[idx] = h[idx] - (c <<< 25);
      end
      if (idx == 4'd9) h[nxt] = h[nxt] + c * 64'sd19;
      else             h[nxt] = h[nxt] + c;
    end
    r = '0;
    for (int n = 0; n < 10; n++) r[32*n +: 32] = h[n][31:0];
    return r;
  endfunction

  assign w_mul_last = (r_cnt == 4'd10);
  assign w_prod     = fe_carry(r_h);
  assign w_t0       = fe_add(r_x1, r_x1);
  assign done       = (r_state == DONE);

  always_comb begin : next_state
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid) w_next = LOAD;
      LOAD:    w_next = MUL1;
      MUL1:    if (w_mul_last) w_next = MUL2;
      MUL2:    if (w_mul_last) w_next = MUL3;
      MUL3:    if (w_mul_last) w_next = MUL4;
      MUL4:    if (w_mul_last) w_next = FINAL;
      FINAL:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin : operand_mux
    w_f = '0;
    w_g = '0;
    case (r_state)
      MUL1:    begin w_f = r_a;  w_g = r_qp; end
      MUL2:    begin w_f = r_b;  w_g = r_qm; end
      MUL3:    begin w_f = r_qt; w_g = r_pt; end
      MUL4:    begin w_f = r_pz; w_g = r_qz; end
      default: begin w_f = '0;   w_g = '0;   end
    endcase
    for (int i = 0; i < 10; i++) w_gl[i] = w_g[32*i +: 32];
  end

  // Column k = r_cnt: j = (k - i) mod 10. Both indices are odd exactly when i is odd and k is even.
  // The product wraps (i + j >= 10) exactly when i > k.
  always_comb begin : column
    logic signed [63:0] fi, gj, prod;
    logic [4:0]         jt;
    fi    = '0;
    gj    = '0;
    prod  = '0;
    jt    = '0;
    w_col = '0;
    for (int i = 0; i < 10; i++) begin
      jt = {1'b0, r_cnt} + 5'd10 - 5'(i);
      if (jt >= 5'd10) jt = jt - 5'd10;
      fi = {{32{w_f[32*i+31]}}, w_f[32*i +: 32]};
      gj = {{32{w_gl[jt[3:0]][31]}}, w_gl[jt[3:0]]};
      prod = fi * gj;
      if ((i % 2 == 1) && !r_cnt[0]) prod = prod <<< 1;
      if (4'(i) > r_cnt) prod = prod * 64'sd19;
      w_col = w_col + prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_px    <= '0; r_py <= '0; r_pz <= '0; r_pt <= '0;
      r_qp    <= '0; r_qm <= '0; r_qz <= '0; r_qt <= '0;
      r_a     <= '0; r_b  <= '0;
      r_z1    <= '0; r_y1 <= '0; r_t1 <= '0; r_x1 <= '0;
      r_h     <= '0;
      r_x     <= '0; r_y  <= '0; r_z  <= '0; r_t  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_px <= p_x;      r_py <= p_y;       r_pz <= p_z; r_pt <= p_t;
            r_qp <= q_yplusx; r_qm <= q_yminusx; r_qz <= q_z; r_qt <= q_t2d;
          end
          r_cnt <= '0;
        end
        LOAD: begin
          r_a   <= fe_add(r_py, r_px);
          r_b   <= fe_sub(r_py, r_px);
          r_cnt <= '0;
        end
        MUL1, MUL2, MUL3, MUL4: begin
          if (w_mul_last) begin
            r_cnt <= '0;
            case (r_state)
              MUL1:    r_z1 <= w_prod;
              MUL2:    r_y1 <= w_prod;
              MUL3:    r_t1 <= w_prod;
              default: r_x1 <= w_prod;
            endcase
          end else begin
            r_h[r_cnt] <= w_col;
            r_cnt      <= r_cnt + 4'd1;
          end
        end
        FINAL: begin
          r_x <= fe_sub(r_z1, r_y1);
          r_y <= fe_add(r_z1, r_y1);
          r_z <= fe_add(w_t0, r_t1);
          r_t <= fe_sub(w_t0, r_t1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ge_add.sv
// Directed bench for ge_add: hand-computed vectors, reset abort, busy valid, back-to-back and done width.
module tb_ge_add;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [319:0] p_x = '0, p_y = '0, p_z = '0, p_t = '0;
  logic [319:0] q_yplusx = '0, q_yminusx = '0, q_z = '0, q_t2d = '0;
  logic [319:0] r_x, r_y, r_z, r_t;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat_ref  = 0;
  int lat      = 0;
  int cnt      = 0;
  logic [1279:0] exp_q[$];
  logic [1279:0] last_exp = '0;

  // Vector 1 constants
  localparam logic [319:0] V1_PX = 320'h00a2384efff6a71aff8cd6df011d7b40ff95f7560133cb410050d046fe377ada007f52ebfee357b0;
  localparam logic [319:0] V1_PY = 320'h00577563010c44b8009dfcf2fe3ff23fffb5525dffa199b10097196500624c9200e087dbfea097ea;
  localparam logic [319:0] V1_PZ = 320'h005fae49ffb4de9b00551e6bfe75c131ff68221ffe7c6fbb00dfdbeffe3ef28eff657c15fe6e55e6;
  localparam logic [319:0] V1_PT = 320'h00cfa961fe14ad41008772f0fe6ac8caff8be8a801e0d67a00ad90effe1fde24ff56ca33ffdab706;
  localparam logic [319:0] V1_QP = 320'hffc3571b019e1efbfff31033fefb05d7fee31a21fed39b5aff514f9bfd5a3eda00f20b2effbcaf5f;
  localparam logic [319:0] V1_QM = 320'h0042f863ff38924d01558c7fff037211ffe04875fd8b8db6004418010070048e00012364036fe1b5;
  localparam logic [319:0] V1_QZ = 320'd1;
  localparam logic [319:0] V1_QT = 320'h0021897d00bd5490ff931565feded0e400fcfe75feb76989004b9cb400af59a6004e2f36fe07d26d;
  localparam logic [319:0] V1_RX = 320'hfe6f9eddfece1c34fe88385300515d300006b28701cc4bb0014169a9027e424c0092303a02519258;
  localparam logic [319:0] V1_RY = 320'h006d7d51fe4e8786ffb33141017c22d800ccfc83fe7596fa00933789002f2b8c008a833c00937912;
  localparam logic [319:0] V1_RZ = 320'h00b8d4f801220b2e00002b64fc53ad89ff2fbdd3fd2bf84a02b6e5c8fc4ba8e0fe3e4957fcb1111a;
  localparam logic [319:0] V1_RT = 320'h00c5e42cfdb16f3e01544e48fd83573bfe70caa9fcc5c6a200c889f4fcb02158ff57a6fdfd08467e;

  always #5 clk = ~clk;

  ge_add dut (
    .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
    .q_yplusx(q_yplusx), .q_yminusx(q_yminusx), .q_z(q_z), .q_t2d(q_t2d),
    .r_x(r_x), .r_y(r_y), .r_z(r_z), .r_t(r_t),
    .clk(clk), .rst(rst), .valid(valid), .done(done)
  );

  function automatic logic [319:0] fe_limb(input int idx, input logic [31:0] v);
    logic [319:0] r;
    r = '0;
    r[32*idx +: 32] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] e);
    n_checks++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int e);
    n_checks++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_op(input logic [319:0] px, input logic [319:0] py, input logic [319:0] pz,
                          input logic [319:0] pt, input logic [319:0] qp, input logic [319:0] qm,
                          input logic [319:0] qz, input logic [319:0] qt);
    p_x = px; p_y = py; p_z = pz; p_t = pt;
    q_yplusx = qp; q_yminusx = qm; q_z = qz; q_t2d = qt;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (done !== 1'b1 && l < 300) begin
      @(posedge clk);
      #1;
      l++;
    end
    check_int("done_seen", int'(done === 1'b1), 1);
  endtask

  task automatic check_result(input string tag);
    if (exp_q.size() == 0) begin
      check_int({tag, "_queue"}, 0, 1);
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_rx"}, r_x, last_exp[1279:960]);
      check({tag, "_ry"}, r_y, last_exp[959:640]);
      check({tag, "_rz"}, r_z, last_exp[639:320]);
      check({tag, "_rt"}, r_t, last_exp[319:0]);
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) c++;
    end
  endtask

  initial begin
    // Reset state
    step(3);
    check("reset_rx", r_x, '0);
    check("reset_rt", r_t, '0);
    check_int("reset_done", int'(done), 0);
    rst = 1'b0;
    step(2);

    // Vector 1
    exp_q.push_back({V1_RX, V1_RY, V1_RZ, V1_RT});
    drive_op(V1_PX, V1_PY, V1_PZ, V1_PT, V1_QP, V1_QM, V1_QZ, V1_QT);
    wait_done(lat_ref);
    check_result("vec1");
    check_int("latency_bound", int'(lat_ref <= 200), 1);
    step(1);
    check_int("done_width", int'(done), 0);
    check("hold1_rx", r_x, last_exp[1279:960]);
    step(5);
    check("hold2_rt", r_t, last_exp[319:0]);

    // Identity: P=(0,1,1,0), Q=(1,1,1,0)
    exp_q.push_back({320'd0, 320'd2, 320'd2, 320'd2});
    drive_op('0, 320'd1, 320'd1, '0, 320'd1, 320'd1, 320'd1, '0);
    wait_done(lat);
    check_result("ident");
    check_int("latency_ident", lat, lat_ref);
    step(2);

    // Small limb-0 values: a=5, b=1, Z1=55, Y1=13, T1=133, X1=85
    exp_q.push_back({320'd42, 320'd68, 320'd303, 320'd37});
    drive_op(320'd2, 320'd3, 320'd5, 320'd7, 320'd11, 320'd13, 320'd17, 320'd19);
    wait_done(lat);
    check_result("small");
    step(2);

    // Wrap: limb9 * limb1, both odd -> 38 into limb 0
    exp_q.push_back({320'd0, 320'd0, 320'd76, 320'd76});
    drive_op('0, '0, fe_limb(9, 32'd1), '0, '0, '0, fe_limb(1, 32'd1), '0);
    wait_done(lat);
    check_result("wrap");
    step(2);

    // Carry: 2^25 * 4 = 2^27 carries 2 into limb 1; r_t limb 0 goes negative
    exp_q.push_back({320'd0, 320'd0, fe_limb(0, 32'd15) | fe_limb(1, 32'd4),
                     fe_limb(0, 32'hFFFFFFF1) | fe_limb(1, 32'd4)});
    drive_op('0, '0, 320'h02000000, 320'd5, 320'd7, 320'd7, 320'd4, 320'd3);
    wait_done(lat);
    check_result("carry");
    step(2);

    // Reset mid-operation: no done, outputs cleared, fresh op still correct
    drive_op(V1_PX, V1_PY, V1_PZ, V1_PT, V1_QP, V1_QM, V1_QZ, V1_QT);
    step(20);
    rst = 1'b1;
    #1;
    check("abort_rx", r_x, '0);
    check("abort_rz", r_z, '0);
    step(1);
    rst = 1'b0;
    count_done(80, cnt);
    check_int("abort_no_done", cnt, 0);
    exp_q.push_back({320'd0, 320'd2, 320'd2, 320'd2});
    drive_op('0, 320'd1, 320'd1, '0, 320'd1, 320'd1, 320'd1, '0);
    wait_done(lat);
    check_result("after_abort");
    step(2);

    // Valid while busy is ignored
    exp_q.push_back({320'd42, 320'd68, 320'd303, 320'd37});
    drive_op(320'd2, 320'd3, 320'd5, 320'd7, 320'd11, 320'd13, 320'd17, 320'd19);
    step(5);
    drive_op(V1_PX, V1_PY, V1_PZ, V1_PT, V1_QP, V1_QM, V1_QZ, V1_QT);
    wait_done(lat);
    check_result("busy");
    count_done(70, cnt);
    check_int("busy_single_done", cnt, 0);

    // Back-to-back: valid in the cycle right after done
    exp_q.push_back({V1_RX, V1_RY, V1_RZ, V1_RT});
    drive_op(V1_PX, V1_PY, V1_PZ, V1_PT, V1_QP, V1_QM, V1_QZ, V1_QT);
    wait_done(lat);
    check_result("b2b_first");
    step(1);
    exp_q.push_back({320'd0, 320'd0, 320'd76, 320'd76});
    drive_op('0, '0, fe_limb(9, 32'd1), '0, '0, '0, fe_limb(1, 32'd1), '0);
    wait_done(lat);
    check_result("b2b_second");
    check_int("latency_b2b", lat, lat_ref);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
